comparator_serial: RTL and testbench

Parametrised, multi-cycle magnitude comparator that extends the 4-bit equality check to WIDTH-bit operands with full eq/gt/lt results and signed/unsigned mode. Operands are captured through a valid/ready handshake and compared CHUNK bits per cycle, most significant chunk first, terminating early at the first differing chunk. It sits in the arithmetic example set as the area-lean alternative to a flat WIDTH-bit comparator, and downstream logic consumes its result through a second handshake.

---
 rtl/comparator_pkg.sv | 21 ++
 rtl/comparator_serial_chunk.sv | 26 ++
 rtl/comparator_serial.sv | 138 +++++++++++++
 tb/tb_comparator_serial.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state type and
// elaboration helpers that derive the chunk count and chunk-index width.
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   // Number of CHUNK-bit slices in a WIDTH-bit operand.
   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of the chunk index counter; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/comparator_serial_chunk.sv
// One CHUNK-bit slice compare. With flip_msb set, both MSBs are inverted so an
// unsigned compare of the slice orders two's-complement values correctly.
module comparator_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_c,
   input  logic [CHUNK-1:0] b_c,
   input  logic             flip_msb,
   output logic             c_eq,
   output logic             c_gt
);

   logic [CHUNK-1:0] w_a_m;
   logic [CHUNK-1:0] w_b_m;

   // Optional sign-bit inversion followed by a plain unsigned compare.
   always_comb begin
      w_a_m            = a_c;
      w_b_m            = b_c;
      w_a_m[CHUNK-1]   = a_c[CHUNK-1] ^ flip_msb;
      w_b_m[CHUNK-1]   = b_c[CHUNK-1] ^ flip_msb;
      c_eq             = (w_a_m == w_b_m);
      c_gt             = (w_a_m >  w_b_m);
   end

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator. Operands are captured on an
// input handshake, then compared CHUNK bits per cycle from the top slice down,
// stopping at the first differing slice. The eq/gt/lt result is offered on an
// output handshake and held until taken.
module comparator_serial
   import comparator_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int               NCHUNK  = nchunk(WIDTH, CHUNK);
   localparam int               IDX_W   = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
         $error("comparator_serial: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   cmp_state_t       r_state;
   cmp_state_t       w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [IDX_W-1:0] r_idx;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;

   logic [CHUNK-1:0] w_a_c;
   logic [CHUNK-1:0] w_b_c;
   logic             w_flip;
   logic             w_c_eq;
   logic             w_c_gt;
   logic             w_last;

   // Select the slice under examination; only the top slice sees the sign flip.
   always_comb begin
      w_a_c  = r_a[r_idx*CHUNK +: CHUNK];
      w_b_c  = r_b[r_idx*CHUNK +: CHUNK];
      w_flip = r_signed && (r_idx == IDX_TOP);
      w_last = (r_idx == '0);
   end

   comparator_chunk #(
      .CHUNK(CHUNK)
   ) u_chunk (
      .a_c      (w_a_c),
      .b_c      (w_b_c),
      .flip_msb (w_flip),
      .c_eq     (w_c_eq),
      .c_gt     (w_c_gt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: accept in IDLE, walk slices in RUN, hold in DONE until taken.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid)            w_next_state = RUN;
         RUN:     if (!w_c_eq || w_last)   w_next_state = DONE;
         DONE:    if (out_ready)           w_next_state = IDLE;
         default:                          w_next_state = IDLE;
      endcase
   end

   // Operand capture, slice index walk and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= '0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_signed <= signed_mode;
                  r_idx    <= IDX_TOP;
               end
            end
            RUN: begin
               if (!w_c_eq) begin
                  r_eq <= 1'b0;
                  r_gt <= w_c_gt;
                  r_lt <= !w_c_gt;
               end else if (w_last) begin
                  r_eq <= 1'b1;
                  r_gt <= 1'b0;
                  r_lt <= 1'b0;
               end else begin
                  r_idx <= r_idx - IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore outputs only; nothing combinational from inputs.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      eq        = r_eq;
      gt        = r_gt;
      lt        = r_lt;
   end

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: directed vector table and handshake corner
// sequences on a 32/4 instance, random traffic against a value-level model,
// and a random sweep over three 8-bit configurations.
module tb_comparator_serial;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
   logic        eq, gt, lt;
   logic [31:0] a, b;

   logic [7:0]  a8, b8;
   logic        sm8, iv8, or8;
   logic [2:0]  ir8, ov8, e8, g8, l8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   comparator_serial #(.WIDTH(32), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .eq(eq), .gt(gt), .lt(lt)
   );

   comparator_serial #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8[0]),
      .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8[0]),
      .out_ready(or8), .eq(e8[0]), .gt(g8[0]), .lt(l8[0])
   );

   comparator_serial #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8[1]),
      .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8[1]),
      .out_ready(or8), .eq(e8[1]), .gt(g8[1]), .lt(l8[1])
   );

   comparator_serial #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8[2]),
      .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8[2]),
      .out_ready(or8), .eq(e8[2]), .gt(g8[2]), .lt(l8[2])
   );

   localparam logic [2:0] F_EQ = 3'b100;
   localparam logic [2:0] F_GT = 3'b010;
   localparam logic [2:0] F_LT = 3'b001;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        sm;
      logic [2:0]  exp_f;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Value-level reference: interpret operands as integers and compare them.
   function automatic logic [2:0] ref_flags(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input int width);
      longint m  = longint'(1) << width;
      longint vx = longint'(x) & (m - 1);
      longint vy = longint'(y) & (m - 1);
      if (s && x[width-1]) vx = vx - m;
      if (s && y[width-1]) vy = vy - m;
      if (vx == vy) return F_EQ;
      return (vx > vy) ? F_GT : F_LT;
   endfunction

   // Latency reference: slices examined = slices down to the one holding the
   // highest differing bit (all of them if equal), plus one for the result cycle.
   function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y,
                                  input int width, input int chunk);
      logic [31:0] d = x ^ y;
      int h = -1;
      for (int i = 0; i < width; i++) if (d[i]) h = i;
      if (h < 0) return width / chunk + 1;
      return width / chunk - h / chunk + 1;
   endfunction

   // One compare on the 32-bit instance; called and returns on a falling edge.
   // Latency counts falling edges after the accepting rising edge.
   task automatic run32(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                        output logic [2:0] f, output int lat);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      a = xa; b = xb; signed_mode = xs; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      f = {eq, gt, lt};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f;
      int          lat;
      logic [31:0] ra, rb;
      logic        rs;
      logic        seen;
      int          ch8[3];
      int          lat8[3];
      logic [2:0]  f8[3];
      logic [2:0]  done;
      int          w;

      ch8[0] = 1; ch8[1] = 8; ch8[2] = 2;

      vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, F_EQ, 9};
      vecs[1] = '{32'h90000000, 32'h10000000, 1'b0, F_GT, 2};
      vecs[2] = '{32'h90000000, 32'h10000000, 1'b1, F_LT, 2};
      vecs[3] = '{32'h00000001, 32'h00000002, 1'b1, F_LT, 9};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, F_GT, 9};
      vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, F_GT, 2};
      vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, F_LT, 2};
      vecs[7] = '{32'h12340000, 32'h12350000, 1'b0, F_LT, 5};
      vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, F_EQ, 9};
      vecs[9] = '{32'h80000000, 32'h80000001, 1'b1, F_LT, 9};

      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; or8 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("reset_state_32", 64'({in_ready, out_valid, eq, gt, lt}), 64'b10000);
      check("reset_state_8", 64'({ir8, ov8, e8, g8, l8}), 64'h7000);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors with out_ready held high.
      for (int i = 0; i < 10; i++) begin
         run32(vecs[i].va, vecs[i].vb, vecs[i].sm, f, lat);
         check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].exp_f));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         @(negedge clk);
         check($sformatf("vec%0d_single_valid", i), 64'({out_valid, in_ready}), 64'b01);
      end

      // Backpressure: result held in DONE while out_ready is low.
      out_ready = 1'b0;
      run32(32'd5, 32'd3, 1'b0, f, lat);
      check("bp_flags", 64'(f), 64'(F_GT));
      check("bp_latency", 64'(lat), 64'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i), 64'({out_valid, in_ready, eq, gt, lt}), 64'b10010);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", 64'({out_valid, in_ready, eq, gt, lt}), 64'b01010);

      // Reset in the middle of a long compare.
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; signed_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset", 64'({in_ready, out_valid, eq, gt, lt}), 64'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrun_no_result", 64'(seen), 64'd0);

      // Random traffic on the 32-bit instance.
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
            default: rb = $urandom;
         endcase
         rs = 1'($urandom_range(0, 1));
         out_ready = 1'b1;
         run32(ra, rb, rs, f, lat);
         check($sformatf("rnd%0d_flags", n), 64'(f), 64'(ref_flags(ra, rb, rs, 32)));
         check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(ref_lat(ra, rb, 32, 4)));
      end

      // Sweep over 8-bit configurations with shared stimulus.
      for (int n = 0; n < 150; n++) begin
         ra = {24'd0, 8'($urandom)};
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (32'h1 << $urandom_range(0, 7));
            default: rb = {24'd0, 8'($urandom)};
         endcase
         rs = 1'($urandom_range(0, 1));
         w = 0;
         while (ir8 != 3'b111 && w < 50) begin
            @(negedge clk);
            w++;
         end
         a8 = ra[7:0]; b8 = rb[7:0]; sm8 = rs; iv8 = 1'b1;
         @(negedge clk);
         iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
         done = 3'b000;
         for (int j = 0; j < 3; j++) begin
            lat8[j] = -1;
            f8[j]   = 3'b000;
         end
         lat = 1;
         while (done != 3'b111 && lat < 20) begin
            for (int j = 0; j < 3; j++) begin
               if (!done[j] && ov8[j]) begin
                  done[j] = 1'b1;
                  lat8[j] = lat;
                  f8[j]   = {e8[j], g8[j], l8[j]};
               end
            end
            if (done != 3'b111) begin
               @(negedge clk);
               lat++;
            end
         end
         for (int j = 0; j < 3; j++) begin
            check($sformatf("sweep%0d_c%0d_flags", n, ch8[j]), 64'(f8[j]),
                  64'(ref_flags(ra, rb, rs, 8)));
            check($sformatf("sweep%0d_c%0d_latency", n, ch8[j]), 64'(lat8[j]),
                  64'(ref_lat(ra, rb, 8, ch8[j])));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
